// File: rtl/sparc_pcx_req_xmit.sv
// sparc_pcx_req_xmit: buffers core PCX packets and issues req/atom to the arbiter,
// tracking per-destination credits that mirror the arbiter's 2-entry source queue.
module sparc_pcx_req_xmit #(
  parameter int NDEST = 5,
  parameter int PKT_W = 124,
  parameter int DEPTH = 4
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             req_vld,
  input  logic [NDEST-1:0] req_dest,
  input  logic             req_atom,
  input  logic [PKT_W-1:0] req_data,
  output logic             req_rdy,
  input  logic [NDEST-1:0] pcx_spc_grant_px,
  output logic [NDEST-1:0] spc_pcx_req_pq,
  output logic [NDEST-1:0] spc_pcx_atom_pq,
  output logic [PKT_W-1:0] spc_pcx_data_pa,
  output logic             spc_pcx_data_vld,
  output logic             credit_ovf_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ATOM1, ATOM2} state_t;
  state_t           state_q, state_d;
  logic [NDEST-1:0] fdest_q [DEPTH];
  logic [NDEST-1:0] fdest_d [DEPTH];
  logic [PKT_W-1:0] fdata_q [DEPTH];
  logic [PKT_W-1:0] fdata_d [DEPTH];
  logic [DEPTH-1:0] fatom_q, fatom_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      fill_q, fill_d;
  logic [1:0]       cred_q [NDEST];
  logic [1:0]       cred_d [NDEST];
  logic [1:0]       eff [NDEST];
  logic [NDEST-1:0] ok1, ok2, sat, req_q, req_d, atm_q, atm_d;
  logic [PKT_W-1:0] out_q, out_d, pend_q, pend_d;
  logic             vld_q, vld_d, pend_vld_q, pend_vld_d, err_q, err_d;
  logic             push, pop, issue;
  logic [NDEST-1:0] hd_dest;
  logic             hd_atom;
  assign req_rdy          = fill_q != (AW+1)'(DEPTH);
  assign spc_pcx_req_pq   = req_q;
  assign spc_pcx_atom_pq  = atm_q;
  assign spc_pcx_data_pa  = out_q;
  assign spc_pcx_data_vld = vld_q;
  assign credit_ovf_err   = err_q;
  always_comb begin
    hd_dest = fdest_q[rd_q];
    hd_atom = fatom_q[rd_q];
    push = req_vld && req_rdy;
    // Grant this cycle counts toward eligibility; req is still a registered output.
    for (int d = 0; d < NDEST; d++) begin
      sat[d] = cred_q[d] == 2'd2;
      eff[d] = pcx_spc_grant_px[d] && !sat[d] ? cred_q[d] + 2'd1 : cred_q[d];
      ok1[d] = eff[d] != 2'd0;
      ok2[d] = eff[d] == 2'd2;
    end
    err_d = err_q || |(pcx_spc_grant_px & sat);
    issue = state_q != ATOM1 && fill_q != '0 &&
            (hd_atom ? fill_q >= (AW+1)'(2) && |(hd_dest & ok2) : |(hd_dest & ok1));
    pop = issue || state_q == ATOM1;
    for (int d = 0; d < NDEST; d++)
      cred_d[d] = eff[d] - (issue && hd_dest[d] ? (hd_atom ? 2'd2 : 2'd1) : 2'd0);
    fdest_d = fdest_q;
    fdata_d = fdata_q;
    fatom_d = fatom_q;
    if (push) begin
      fdest_d[wr_q] = req_dest;
      fdata_d[wr_q] = req_data;
      fatom_d[wr_q] = req_atom;
    end
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    fill_d = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q == ATOM1 ? ATOM2 : issue && hd_atom ? ATOM1 : IDLE;
    req_d = issue ? hd_dest : '0;
    atm_d = issue && hd_atom ? hd_dest : '0;
    pend_vld_d = pop;
    pend_d = pop ? fdata_q[rd_q] : pend_q;
    vld_d = pend_vld_q;
    out_d = pend_vld_q ? pend_q : out_q;
  end
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        fdest_q[i] <= '0;
        fdata_q[i] <= '0;
      end
      fatom_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fill_q     <= '0;
      for (int d = 0; d < NDEST; d++) cred_q[d] <= 2'd2;
      req_q      <= '0;
      atm_q      <= '0;
      out_q      <= '0;
      pend_q     <= '0;
      vld_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fdest_q    <= fdest_d;
      fdata_q    <= fdata_d;
      fatom_q    <= fatom_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fill_q     <= fill_d;
      cred_q     <= cred_d;
      req_q      <= req_d;
      atm_q      <= atm_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      vld_q      <= vld_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_sparc_pcx_req_xmit.sv
// tb_sparc_pcx_req_xmit: directed scenarios plus random traffic against a queue-based model.
module tb_sparc_pcx_req_xmit;
  localparam int NDEST = 5, PKT_W = 124, DEPTH = 4;
  logic rclk = 0, reset = 1, req_vld = 0, req_atom = 0;
  logic req_rdy, spc_pcx_data_vld, credit_ovf_err;
  logic [NDEST-1:0] req_dest = '0, pcx_spc_grant_px = '0, spc_pcx_req_pq, spc_pcx_atom_pq;
  logic [PKT_W-1:0] req_data = '0, spc_pcx_data_pa;
  int total = 0, bad = 0;
  typedef struct {logic [NDEST-1:0] d; bit a; logic [PKT_W-1:0] x;} pkt_t;
  pkt_t q[$];
  int mcnt[NDEST];
  bit m_a1, pend_v, exp_dv, exp_err, exp_rdy;
  logic [PKT_W-1:0] pend_x, exp_data;
  logic [NDEST-1:0] exp_req, exp_atom;

  always #5 rclk = ~rclk;

  sparc_pcx_req_xmit #(.NDEST(NDEST), .PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .rclk(rclk), .reset(reset), .req_vld(req_vld), .req_dest(req_dest), .req_atom(req_atom),
    .req_data(req_data), .req_rdy(req_rdy), .pcx_spc_grant_px(pcx_spc_grant_px),
    .spc_pcx_req_pq(spc_pcx_req_pq), .spc_pcx_atom_pq(spc_pcx_atom_pq),
    .spc_pcx_data_pa(spc_pcx_data_pa), .spc_pcx_data_vld(spc_pcx_data_vld),
    .credit_ovf_err(credit_ovf_err));

  function automatic logic [PKT_W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[PKT_W-1:0];
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int d = 0; d < NDEST; d++) mcnt[d] = 2;
    m_a1 = 0; pend_v = 0; exp_dv = 0; exp_err = 0; exp_rdy = 1;
    pend_x = '0; exp_data = '0; exp_req = '0; exp_atom = '0;
  endfunction

  // One clock of the transmitter as described behaviourally: credits, in-order queue, data one cycle behind req.
  function automatic void model_tick();
    bit rdy = q.size() < DEPTH;
    bit iss = 0;
    int eff[NDEST];
    pkt_t h = '{d: '0, a: 0, x: '0};
    for (int d = 0; d < NDEST; d++) begin
      if (pcx_spc_grant_px[d] && mcnt[d] == 2) exp_err = 1;
      eff[d] = mcnt[d] + int'(pcx_spc_grant_px[d]);
      if (eff[d] > 2) eff[d] = 2;
    end
    if (!m_a1 && q.size() > 0) begin
      h = q[0];
      for (int d = 0; d < NDEST; d++)
        if (h.d[d]) iss = h.a ? (q.size() >= 2 && eff[d] == 2) : eff[d] >= 1;
    end
    exp_dv = pend_v;
    if (pend_v) exp_data = pend_x;
    pend_v = 0;
    if (m_a1) begin
      pend_x = q.pop_front().x; pend_v = 1; m_a1 = 0;
    end else if (iss) begin
      void'(q.pop_front()); pend_x = h.x; pend_v = 1; m_a1 = h.a;
    end
    exp_req = iss ? h.d : '0;
    exp_atom = iss && h.a ? h.d : '0;
    for (int d = 0; d < NDEST; d++) mcnt[d] = eff[d] - ((iss && h.d[d]) ? (h.a ? 2 : 1) : 0);
    if (req_vld && rdy) q.push_back('{d: req_dest, a: req_atom, x: req_data});
    exp_rdy = q.size() < DEPTH;
  endfunction

  task automatic step(bit v, logic [NDEST-1:0] d, bit a, logic [PKT_W-1:0] x, logic [NDEST-1:0] g);
    req_vld = v; req_dest = d; req_atom = a; req_data = x; pcx_spc_grant_px = g;
    @(posedge rclk);
    model_tick();
    #1;
    req_vld = 0; pcx_spc_grant_px = '0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    #2;
    @(posedge rclk);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    #2;
    total += 6;
    if (spc_pcx_req_pq !== '0) begin bad++; $display("FAIL rst_req got=%b want=0", spc_pcx_req_pq); end
    if (spc_pcx_atom_pq !== '0) begin bad++; $display("FAIL rst_atom got=%b want=0", spc_pcx_atom_pq); end
    if (spc_pcx_data_vld !== 0) begin bad++; $display("FAIL rst_dvld got=%b want=0", spc_pcx_data_vld); end
    if (spc_pcx_data_pa !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", spc_pcx_data_pa); end
    if (credit_ovf_err !== 0) begin bad++; $display("FAIL rst_err got=%b want=0", credit_ovf_err); end
    if (req_rdy !== 1) begin bad++; $display("FAIL rst_rdy got=%b want=1", req_rdy); end
    do_reset();
  endtask

  task automatic test_single();
    logic [PKT_W-1:0] x = rnd(), a1 = rnd(), a2 = rnd();
    do_reset();
    step(1, 5'b00001, 0, x, '0);
    total++;
    if (spc_pcx_req_pq !== '0) begin bad++; $display("FAIL t1_early got=%b want=0", spc_pcx_req_pq); end
    idle(1);
    total += 2;
    if (spc_pcx_req_pq !== 5'b00001) begin bad++; $display("FAIL t1_req got=%b want=00001", spc_pcx_req_pq); end
    if (spc_pcx_atom_pq !== '0) begin bad++; $display("FAIL t1_atom got=%b want=0", spc_pcx_atom_pq); end
    idle(1);
    total += 3;
    if (spc_pcx_data_vld !== 1) begin bad++; $display("FAIL t1_dvld got=%b want=1", spc_pcx_data_vld); end
    if (spc_pcx_data_pa !== x) begin bad++; $display("FAIL t1_data got=%h want=%h", spc_pcx_data_pa, x); end
    if (spc_pcx_req_pq !== '0) begin bad++; $display("FAIL t1_req_off got=%b want=0", spc_pcx_req_pq); end
    step(0, '0, 0, '0, 5'b00001);
    step(1, 5'b00001, 1, a1, '0);
    step(1, 5'b00001, 0, a2, '0);
    idle(1);
    total++;
    if (spc_pcx_atom_pq !== 5'b00001) begin bad++; $display("FAIL t1_credit_back got=%b want=00001", spc_pcx_atom_pq); end
  endtask

  task automatic test_credit_stall();
    logic [PKT_W-1:0] p3 = rnd();
    int n = 0;
    do_reset();
    step(1, 5'b00100, 0, rnd(), '0);
    n += int'(spc_pcx_req_pq != '0);
    step(1, 5'b00100, 0, rnd(), '0);
    n += int'(spc_pcx_req_pq != '0);
    step(1, 5'b00100, 0, p3, '0);
    n += int'(spc_pcx_req_pq != '0);
    for (int i = 0; i < 6; i++) begin idle(1); n += int'(spc_pcx_req_pq != '0); end
    total++;
    if (n !== 2) begin bad++; $display("FAIL t2_req_count got=%0d want=2", n); end
    step(0, '0, 0, '0, 5'b00100);
    total++;
    if (spc_pcx_req_pq !== 5'b00100) begin bad++; $display("FAIL t2_after_grant got=%b want=00100", spc_pcx_req_pq); end
    idle(1);
    total++;
    if (spc_pcx_data_pa !== p3 || spc_pcx_data_vld !== 1) begin
      bad++; $display("FAIL t2_data got=%h/%b want=%h/1", spc_pcx_data_pa, spc_pcx_data_vld, p3);
    end
  endtask

  task automatic test_atomic();
    logic [PKT_W-1:0] a1 = rnd(), a2 = rnd();
    int n = 0;
    do_reset();
    step(1, 5'b00010, 1, a1, '0);
    step(1, 5'b00010, 0, a2, '0);
    idle(1);
    total++;
    if (spc_pcx_req_pq !== 5'b00010 || spc_pcx_atom_pq !== 5'b00010) begin
      bad++; $display("FAIL t3_req got=%b/%b want=00010/00010", spc_pcx_req_pq, spc_pcx_atom_pq);
    end
    idle(1);
    total += 2;
    if (spc_pcx_req_pq !== '0) begin bad++; $display("FAIL t3_gap got=%b want=0", spc_pcx_req_pq); end
    if (spc_pcx_data_pa !== a1 || spc_pcx_data_vld !== 1) begin bad++; $display("FAIL t3_half1 got=%h want=%h", spc_pcx_data_pa, a1); end
    idle(1);
    total++;
    if (spc_pcx_data_pa !== a2 || spc_pcx_data_vld !== 1) begin bad++; $display("FAIL t3_half2 got=%h want=%h", spc_pcx_data_pa, a2); end
    idle(1);
    total++;
    if (spc_pcx_data_pa !== a2 || spc_pcx_data_vld !== 0) begin
      bad++; $display("FAIL t3_hold got=%h/%b want=%h/0", spc_pcx_data_pa, spc_pcx_data_vld, a2);
    end
    step(1, 5'b00010, 0, rnd(), '0);
    for (int i = 0; i < 4; i++) begin idle(1); n += int'(spc_pcx_req_pq != '0); end
    total++;
    if (n !== 0) begin bad++; $display("FAIL t3_cnt_zero got=%0d want=0", n); end
  endtask

  task automatic test_atomic_wait();
    int n = 0;
    do_reset();
    step(1, 5'b00010, 0, rnd(), '0);
    step(1, 5'b00010, 1, rnd(), '0);
    total++;
    if (spc_pcx_req_pq !== 5'b00010) begin bad++; $display("FAIL t4_first got=%b want=00010", spc_pcx_req_pq); end
    step(1, 5'b00010, 0, rnd(), '0);
    n += int'(spc_pcx_req_pq != '0);
    step(1, 5'b01000, 0, rnd(), '0);
    n += int'(spc_pcx_req_pq != '0);
    for (int i = 0; i < 5; i++) begin idle(1); n += int'(spc_pcx_req_pq != '0); end
    total++;
    if (n !== 0) begin bad++; $display("FAIL t4_blocked got=%0d want=0", n); end
    step(0, '0, 0, '0, 5'b00010);
    total++;
    if (spc_pcx_req_pq !== 5'b00010 || spc_pcx_atom_pq !== 5'b00010) begin
      bad++; $display("FAIL t4_atom_go got=%b/%b want=00010/00010", spc_pcx_req_pq, spc_pcx_atom_pq);
    end
    idle(1);
    total++;
    if (spc_pcx_req_pq !== '0) begin bad++; $display("FAIL t4_gap got=%b want=0", spc_pcx_req_pq); end
    idle(1);
    total++;
    if (spc_pcx_req_pq !== 5'b01000 || spc_pcx_atom_pq !== '0) begin
      bad++; $display("FAIL t4_younger got=%b/%b want=01000/0", spc_pcx_req_pq, spc_pcx_atom_pq);
    end
  endtask

  task automatic test_grant_issue();
    int n = 0;
    do_reset();
    step(1, 5'b01000, 0, rnd(), '0);
    idle(1);
    step(1, 5'b01000, 0, rnd(), '0);
    step(0, '0, 0, '0, 5'b01000);
    total++;
    if (spc_pcx_req_pq !== 5'b01000) begin bad++; $display("FAIL t5_same_cycle got=%b want=01000", spc_pcx_req_pq); end
    step(1, 5'b01000, 0, rnd(), '0);
    n += int'(spc_pcx_req_pq != '0);
    step(1, 5'b01000, 0, rnd(), '0);
    n += int'(spc_pcx_req_pq != '0);
    for (int i = 0; i < 4; i++) begin idle(1); n += int'(spc_pcx_req_pq != '0); end
    total += 2;
    if (n !== 1) begin bad++; $display("FAIL t5_cnt_one got=%0d want=1", n); end
    if (credit_ovf_err !== 0) begin bad++; $display("FAIL t5_no_err got=%b want=0", credit_ovf_err); end
    do_reset();
    step(0, '0, 0, '0, 5'b00001);
    total++;
    if (credit_ovf_err !== 1) begin bad++; $display("FAIL t5_ovf got=%b want=1", credit_ovf_err); end
    idle(2);
    total++;
    if (credit_ovf_err !== 1) begin bad++; $display("FAIL t5_sticky got=%b want=1", credit_ovf_err); end
  endtask

  task automatic test_reset_mid();
    logic [PKT_W-1:0] b1 = rnd();
    int n = 0;
    do_reset();
    step(1, 5'b00010, 1, rnd(), '0);
    step(1, 5'b00010, 0, rnd(), '0);
    idle(2);
    reset = 1;
    #1;
    total += 5;
    if (spc_pcx_req_pq !== '0) begin bad++; $display("FAIL t6_req got=%b want=0", spc_pcx_req_pq); end
    if (spc_pcx_atom_pq !== '0) begin bad++; $display("FAIL t6_atom got=%b want=0", spc_pcx_atom_pq); end
    if (spc_pcx_data_vld !== 0) begin bad++; $display("FAIL t6_dvld got=%b want=0", spc_pcx_data_vld); end
    if (spc_pcx_data_pa !== '0) begin bad++; $display("FAIL t6_data got=%h want=0", spc_pcx_data_pa); end
    if (req_rdy !== 1) begin bad++; $display("FAIL t6_rdy got=%b want=1", req_rdy); end
    model_reset();
    @(posedge rclk);
    #1 reset = 0;
    for (int i = 0; i < 4; i++) begin idle(1); n += int'(spc_pcx_data_vld != 0 || spc_pcx_req_pq != '0); end
    total++;
    if (n !== 0) begin bad++; $display("FAIL t6_quiet got=%0d want=0", n); end
    step(1, 5'b00010, 1, b1, '0);
    step(1, 5'b00010, 0, rnd(), '0);
    idle(1);
    total++;
    if (spc_pcx_atom_pq !== 5'b00010) begin bad++; $display("FAIL t6_fresh got=%b want=00010", spc_pcx_atom_pq); end
    idle(1);
    total++;
    if (spc_pcx_data_pa !== b1) begin bad++; $display("FAIL t6_fresh_data got=%h want=%h", spc_pcx_data_pa, b1); end
  endtask

  task automatic test_random();
    bit need2 = 0, v, a;
    logic [NDEST-1:0] pd = '0, d, g;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v = $urandom_range(1) == 1;
      if (need2) begin d = pd; a = 0; end
      else begin d = '0; d[$urandom_range(NDEST-1)] = 1'b1; a = $urandom_range(3) == 0; end
      for (int k = 0; k < NDEST; k++) g[k] = mcnt[k] < 2 && $urandom_range(2) == 0;
      if (v && q.size() < DEPTH) begin need2 = a; pd = d; end
      step(v, d, a, rnd(), g);
      total += 6;
      if (spc_pcx_req_pq !== exp_req) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", i, spc_pcx_req_pq, exp_req); end
      if (spc_pcx_atom_pq !== exp_atom) begin bad++; $display("FAIL rnd_atom cyc=%0d got=%b want=%b", i, spc_pcx_atom_pq, exp_atom); end
      if (spc_pcx_data_vld !== exp_dv) begin bad++; $display("FAIL rnd_dvld cyc=%0d got=%b want=%b", i, spc_pcx_data_vld, exp_dv); end
      if (spc_pcx_data_pa !== exp_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, spc_pcx_data_pa, exp_data); end
      if (req_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b want=%b", i, req_rdy, exp_rdy); end
      if (credit_ovf_err !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", i, credit_ovf_err, exp_err); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_credit_stall();
    test_atomic();
    test_atomic_wait();
    test_grant_issue();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
